// File: rtl/demux_destino_pkg.sv
// Shared definitions for the egress destination router.
package demux_destino_pkg;

  localparam int DEST_W   = 2;
  localparam int NUM_DEST = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Destination index to one-hot push vector.
  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    logic [NUM_DEST-1:0] oh;
    oh       = '0;
    oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_hold_buf.sv
// Two-entry in-order hold buffer; accepts push and pop in the same cycle.
module demux_hold_buf #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_destino.sv
// Egress router: drains the mid FIFO and steers each word to one of four
// destination FIFOs by its 2-bit destination field, holding words in order
// while their destination is almost full.
//
//   state     | meaning
//   ST_IDLE   | no new pops; in-flight and held words still drain
//   ST_ACTIVE | pops issued whenever the mid FIFO has data and nothing is held
module demux_destino
  import demux_destino_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int DEST_LSB = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              empty_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              pop_in,
  input  logic              almost_full0,
  input  logic              almost_full1,
  input  logic              almost_full2,
  input  logic              almost_full3,
  output logic              push0,
  output logic              push1,
  output logic              push2,
  output logic              push3,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
);

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic [NUM_DEST-1:0]   af;
  logic [NUM_DEST-1:0]   push_q;
  logic [DATA_W-1:0]     hold_head;
  logic [1:0]            hold_count;
  logic [DEST_W-1:0]     dest_in;
  logic [DEST_W-1:0]     head_dest;
  logic                  drain;
  logic                  direct;
  logic                  hold_push;

  assign af        = {almost_full3, almost_full2, almost_full1, almost_full0};
  assign {push3, push2, push1, push0} = push_q;
  assign dest_in   = data_in[DEST_LSB +: DEST_W];
  assign head_dest = hold_head[DEST_LSB +: DEST_W];

  // Held head leaves first; a new arrival goes direct only when nothing is held.
  assign drain     = (hold_count != 2'd0) & ~af[head_dest];
  assign direct    = inflight & (hold_count == 2'd0) & ~af[dest_in];
  assign hold_push = inflight & ~direct;

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and pop request; pop is forced low during reset.
  always_comb begin
    state_nxt = state;
    pop_in    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) state_nxt = ST_IDLE;
        pop_in = reset_L & ~empty_in & (hold_count == 2'd0);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read data from the mid FIFO is valid the cycle after the pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) inflight <= 1'b0;
    else          inflight <= pop_in;
  end

  demux_hold_buf #(.W(DATA_W)) u_hold (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (hold_push),
    .pop     (drain),
    .din     (data_in),
    .head    (hold_head),
    .count   (hold_count)
  );

  // Registered push; data_out keeps its last value when nothing is pushed.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_q   <= '0;
      data_out <= '0;
    end else if (drain) begin
      push_q   <= dest_onehot(head_dest);
      data_out <= hold_head;
    end else if (direct) begin
      push_q   <= dest_onehot(dest_in);
      data_out <= data_in;
    end else begin
      push_q   <= '0;
    end
  end

  assign idle = ~inflight & (hold_count == 2'd0) & ~(|push_q) &
                (empty_in | (state == ST_IDLE));

endmodule

// File: tb/tb_demux_destino.sv
module tb_demux_destino;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic       empty_in = 1'b1;
  logic [5:0] data_in = '0;
  logic       pop_in;
  logic [3:0] af = '0;
  logic       push0, push1, push2, push3;
  logic [5:0] data_out;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [5:0] mid_q [$];
  logic [5:0] exp_q [4][$];

  int fp;
  int np;
  int pc [16];
  logic [3:0] pd [16];

  demux_destino #(.DATA_W(6), .DEST_LSB(4)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .enable       (enable),
    .empty_in     (empty_in),
    .data_in      (data_in),
    .pop_in       (pop_in),
    .almost_full0 (af[0]),
    .almost_full1 (af[1]),
    .almost_full2 (af[2]),
    .almost_full3 (af[3]),
    .push0        (push0),
    .push1        (push1),
    .push2        (push2),
    .push3        (push3),
    .data_out     (data_out),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mid FIFO model: read data appears one cycle after pop; popped words
  // become expectations for their destination.
  always @(posedge clk) begin
    logic       p;
    logic [5:0] w;
    p = pop_in;
    #1;
    if (p) begin
      if (mid_q.size() == 0) begin
        chk("pop_from_empty", 1, 0);
      end else begin
        w = mid_q.pop_front();
        data_in = w;
        exp_q[w[5:4]].push_back(w);
      end
    end
    empty_in = (mid_q.size() == 0);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [3:0] p;
    logic [5:0] e;
    p = {push3, push2, push1, push0};
    if (reset_L && (p != 4'b0)) begin
      chk("push_onehot", $countones(p), 1);
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_push%0d", k), int'(data_out), -1);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("push%0d_data", k), int'(data_out), int'(e));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] w);
    mid_q.push_back(w);
  endtask

  // Record first pop and every push over n cycles.
  task automatic capture(input int n);
    fp = -1;
    np = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pop_in && fp < 0) fp = cyc;
      if ({push3, push2, push1, push0} != 4'b0 && np < 16) begin
        pc[np] = cyc;
        pd[np] = {push3, push2, push1, push0};
        np++;
      end
    end
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  initial begin
    logic [5:0] w;
    int         loaded;
    int         done;

    // Reset values
    reset_L = 1'b0;
    #12;
    chk("rst_push", int'({push3, push2, push1, push0}), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_pop", int'(pop_in), 0);
    step(1);
    reset_L = 1'b1;
    step(2);

    // One word to each destination, back to back
    load(6'h05); load(6'h1A); load(6'h2F); load(6'h30);
    step(2);
    enable = 1'b1;
    capture(14);
    chk("t1_npush", np, 4);
    chk("t1_latency", pc[0] - fp, 2);
    for (int i = 1; i < 4; i++) chk("t1_consecutive", pc[i] - pc[0], i);
    for (int i = 0; i < 4; i++) chk("t1_dest", int'(pd[i]), 1 << i);
    chk("t1_idle", int'(idle), 1);

    // Destination 1 blocked: later words queue behind it
    step(1);
    af[1] = 1'b1;
    load(6'h11); load(6'h02); load(6'h23);
    capture(8);
    chk("t2_no_push", np, 0);
    chk("t2_pop_blocked", int'(pop_in), 0);
    chk("t2_hold_count", int'(dut.hold_count), 2);
    chk("t2_not_idle", int'(idle), 0);
    step(1);
    af[1] = 1'b0;
    capture(10);
    chk("t2_npush", np, 3);
    chk("t2_first_dest1", int'(pd[0]), 4'b0010);
    chk("t2_then_dest0", int'(pd[1]), 4'b0001);
    chk("t2_back_to_back", pc[1] - pc[0], 1);
    chk("t2_then_dest2", int'(pd[2]), 4'b0100);

    // Dest 2 blocked with two words in flight
    step(1);
    af[2] = 1'b1;
    load(6'h20); load(6'h21); load(6'h22);
    capture(8);
    chk("t3_no_push", np, 0);
    chk("t3_hold_count", int'(dut.hold_count), 2);
    chk("t3_pop_blocked", int'(pop_in), 0);
    step(1);
    af[2] = 1'b0;
    capture(10);
    chk("t3_npush", np, 3);
    chk("t3_none_lost", pending(), 0);

    // Enable dropped mid-stream
    step(1);
    load(6'h05); load(6'h06); load(6'h07); load(6'h08);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (pop_in) done = 1;
    end
    chk("t4_saw_pop", done, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t4_pop_stopped", int'(pop_in), 0);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (idle) done = 1;
    end
    chk("t4_idle_after_drain", done, 1);
    chk("t4_inflight_pushed", pending(), 0);
    chk("t4_words_left", (mid_q.size() > 0) ? 1 : 0, 1);
    mid_q.delete();

    // Reset while two words are held
    step(2);
    af[3] = 1'b1;
    load(6'h30); load(6'h31); load(6'h32);
    enable = 1'b1;
    step(8);
    @(negedge clk);
    chk("t5_hold_count", int'(dut.hold_count), 2);
    reset_L = 1'b0;
    #1;
    chk("t5_rst_push", int'({push3, push2, push1, push0}), 0);
    chk("t5_rst_idle", int'(idle), 1);
    chk("t5_rst_pop", int'(pop_in), 0);
    step(3);
    mid_q.delete();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    af[3] = 1'b0;
    step(1);
    reset_L = 1'b1;
    capture(8);
    chk("t5_no_stale_push", np, 0);
    chk("t5_idle_after", int'(idle), 1);

    // Random stress
    loaded = 0;
    for (int c = 0; c < 40000 && loaded < 2000; c++) begin
      step(1);
      for (int b = 0; b < 4; b++) af[b] = ($urandom_range(0, 9) < 3);
      if (mid_q.size() < 3) begin
        w = 6'($urandom_range(0, 63));
        load(w);
        loaded++;
      end
    end
    chk("t6_loaded", loaded, 2000);
    af = '0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (idle && mid_q.size() == 0 && pending() == 0) done = 1;
    end
    chk("t6_drained", done, 1);
    chk("t6_pending", pending(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
